// File: rtl/dsp_alu_dispatch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dsp_alu_dispatch_pkg
// Description : Shared ALU opcodes and dispatch-stage state encodings.
// Revision    : 1.0 - initial release
// ============================================================================
package dsp_alu_dispatch_pkg;

  localparam logic [7:0] ALU_OP_NOP       = 8'h00;
  localparam logic [7:0] ALU_OP_ADD       = 8'h01;
  localparam logic [7:0] ALU_OP_SUB       = 8'h02;
  localparam logic [7:0] ALU_OP_MIN       = 8'h03;
  localparam logic [7:0] ALU_OP_MAX       = 8'h04;
  localparam logic [7:0] ALU_OP_ABS       = 8'h05;
  localparam logic [7:0] ALU_OP_SAT       = 8'h06;
  localparam logic [7:0] ALU_OP_CLAMP     = 8'h07;
  localparam logic [7:0] ALU_OP_LSH       = 8'h08;
  localparam logic [7:0] ALU_OP_RSH       = 8'h09;
  localparam logic [7:0] ALU_OP_ARSH      = 8'h0A;
  localparam logic [7:0] ALU_OP_ARSH_WIDE = 8'h0B;
  localparam logic [7:0] ALU_OP_MUL       = 8'h0C;
  localparam logic [7:0] ALU_OP_MADD      = 8'h0D;
  localparam logic [7:0] ALU_OP_MAC       = 8'h0E;
  localparam logic [7:0] ALU_OP_LINTERP   = 8'h0F;

  typedef enum logic [1:0] {
    DISP_STATE_IDLE = 2'd0,
    DISP_STATE_FAST = 2'd1,
    DISP_STATE_WAIT = 2'd2
  } disp_state_e;

  typedef enum logic [1:0] {
    OP_CLASS_NONE = 2'd0,
    OP_CLASS_FAST = 2'd1,
    OP_CLASS_SLOW = 2'd2
  } op_class_e;

endpackage
`default_nettype wire

// File: rtl/dsp_cmd_fifo.sv
`default_nettype none
// ============================================================================
// Module      : dsp_cmd_fifo
// Description : Synchronous command FIFO with registered full/empty flags.
// Revision    : 1.0 - initial release
// ============================================================================
module dsp_cmd_fifo #(
  parameter int width = 8,
  parameter int depth = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [width-1:0] wr_data,
  input  logic             pop,
  output logic [width-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(depth);

  logic [width-1:0] mem_q [depth];
  logic [width-1:0] mem_d [depth];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      mem_d[wr_ptr_q] = wr_data;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    count_d = count_q + (AW+1)'(push) - (AW+1)'(pop);
    full_d  = (count_d == (AW+1)'(depth));
    empty_d = (count_d == '0);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < depth; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  assign rd_data = mem_q[rd_ptr_q];
  assign full    = full_q;
  assign empty   = empty_q;

endmodule
`default_nettype wire

// File: rtl/dsp_alu_dispatch.sv
`default_nettype none
// ============================================================================
// Module      : dsp_alu_dispatch
// Description : Queues ALU commands, issues them one at a time, captures
//               tagged results and watchdogs multi-cycle ops.
// Revision    : 1.0 - initial release
// ============================================================================
module dsp_alu_dispatch
  import dsp_alu_dispatch_pkg::*;
#(
  parameter int data_width = 16,
  parameter int depth      = 4,
  parameter int tag_width  = 4,
  parameter int timeout    = 255
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [7:0]                    in_op,
  input  logic [data_width-1:0]         in_a,
  input  logic [data_width-1:0]         in_b,
  input  logic [data_width-1:0]         in_c,
  input  logic [2*data_width-1:0]       in_a_wide,
  input  logic [2*data_width-1:0]       in_b_wide,
  input  logic [$clog2(data_width)-1:0] in_shift,
  input  logic                          in_no_shift,
  input  logic                          in_saturate,
  input  logic [tag_width-1:0]          in_tag,
  output logic                          alu_trigger,
  output logic [7:0]                    alu_op,
  output logic [data_width-1:0]         alu_a,
  output logic [data_width-1:0]         alu_b,
  output logic [data_width-1:0]         alu_c,
  output logic [2*data_width-1:0]       alu_a_wide,
  output logic [2*data_width-1:0]       alu_b_wide,
  output logic [$clog2(data_width)-1:0] alu_shift,
  output logic                          alu_no_shift,
  output logic                          alu_saturate,
  input  logic [data_width-1:0]         alu_result,
  input  logic [2*data_width-1:0]       alu_result_wide,
  input  logic                          alu_result_valid,
  input  logic                          alu_ready,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [data_width-1:0]         out_result,
  output logic [2*data_width-1:0]       out_result_wide,
  output logic                          out_is_wide,
  output logic [tag_width-1:0]          out_tag,
  output logic                          out_err
);

  localparam int SW     = $clog2(data_width);
  localparam int OPND_W = 7*data_width + SW + 2;
  localparam int CMD_W  = 8 + OPND_W + tag_width;
  localparam int WD_W   = $clog2(timeout + 1);

  function automatic op_class_e op_class(input logic [7:0] op);
    case (op)
      ALU_OP_ADD, ALU_OP_SUB, ALU_OP_MIN, ALU_OP_MAX,
      ALU_OP_ABS, ALU_OP_SAT, ALU_OP_CLAMP:
        op_class = OP_CLASS_FAST;
      ALU_OP_LSH, ALU_OP_RSH, ALU_OP_ARSH, ALU_OP_ARSH_WIDE,
      ALU_OP_MUL, ALU_OP_MADD, ALU_OP_MAC, ALU_OP_LINTERP:
        op_class = OP_CLASS_SLOW;
      default:
        op_class = OP_CLASS_NONE;
    endcase
  endfunction

  logic                 fifo_full, fifo_empty, push, pop, issue;
  logic [CMD_W-1:0]     head;
  logic [7:0]           head_op;
  logic [OPND_W-1:0]    head_opnd;
  logic [tag_width-1:0] head_tag;
  op_class_e            head_class;

  disp_state_e             state_q, state_d;
  logic [7:0]              cur_op_q, cur_op_d;
  logic [tag_width-1:0]    cur_tag_q, cur_tag_d;
  logic [OPND_W-1:0]       opnd_q, opnd_d;
  logic [WD_W-1:0]         wd_q, wd_d;
  logic                    out_valid_q, out_valid_d;
  logic [data_width-1:0]   out_result_q, out_result_d;
  logic [2*data_width-1:0] out_result_wide_q, out_result_wide_d;
  logic                    out_is_wide_q, out_is_wide_d;
  logic [tag_width-1:0]    out_tag_q, out_tag_d;
  logic                    out_err_q, out_err_d;

  assign push     = in_valid && !fifo_full;
  assign in_ready = !fifo_full;

  dsp_cmd_fifo #(
    .width (CMD_W),
    .depth (depth)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (push),
    .wr_data ({in_op, in_a, in_b, in_c, in_a_wide, in_b_wide,
               in_shift, in_no_shift, in_saturate, in_tag}),
    .pop     (pop),
    .rd_data (head),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign {head_op, head_opnd, head_tag} = head;
  assign head_class = op_class(head_op);

  // Unclassified opcodes are popped without ever reaching the ALU bus.
  assign pop   = (state_q == DISP_STATE_IDLE) && !fifo_empty && alu_ready &&
                 (!out_valid_q || out_ready);
  assign issue = pop && (head_class != OP_CLASS_NONE);

  // The ALU sees the FIFO head in the issue cycle itself; otherwise NOP with
  // operands parked at their last issued values.
  assign alu_op      = issue ? head_op : ALU_OP_NOP;
  assign alu_trigger = issue && (head_class == OP_CLASS_SLOW);
  assign {alu_a, alu_b, alu_c, alu_a_wide, alu_b_wide,
          alu_shift, alu_no_shift, alu_saturate} = issue ? head_opnd : opnd_q;

  always_comb begin
    state_d           = state_q;
    cur_op_d          = cur_op_q;
    cur_tag_d         = cur_tag_q;
    opnd_d            = opnd_q;
    wd_d              = wd_q;
    out_valid_d       = out_valid_q && !out_ready;
    out_result_d      = out_result_q;
    out_result_wide_d = out_result_wide_q;
    out_is_wide_d     = out_is_wide_q;
    out_tag_d         = out_tag_q;
    out_err_d         = out_err_q;
    case (state_q)
      DISP_STATE_IDLE: begin
        if (issue) begin
          opnd_d    = head_opnd;
          cur_op_d  = head_op;
          cur_tag_d = head_tag;
          wd_d      = '0;
          state_d   = (head_class == OP_CLASS_SLOW) ? DISP_STATE_WAIT : DISP_STATE_FAST;
        end
      end
      DISP_STATE_FAST: begin
        out_valid_d       = 1'b1;
        out_result_d      = (cur_op_q == ALU_OP_CLAMP) ? alu_result_wide[data_width-1:0]
                                                       : alu_result;
        out_result_wide_d = '0;
        out_is_wide_d     = 1'b0;
        out_tag_d         = cur_tag_q;
        out_err_d         = 1'b0;
        state_d           = DISP_STATE_IDLE;
      end
      DISP_STATE_WAIT: begin
        if (alu_result_valid) begin
          out_valid_d       = 1'b1;
          out_result_d      = alu_result;
          out_result_wide_d = alu_result_wide;
          out_is_wide_d     = (cur_op_q == ALU_OP_MAC) || (cur_op_q == ALU_OP_ARSH_WIDE);
          out_tag_d         = cur_tag_q;
          out_err_d         = 1'b0;
          state_d           = DISP_STATE_IDLE;
        end else if (wd_q == WD_W'(timeout - 1)) begin
          // Last permitted WAIT cycle elapsed: report an aborted, zeroed result.
          out_valid_d       = 1'b1;
          out_result_d      = '0;
          out_result_wide_d = '0;
          out_is_wide_d     = 1'b0;
          out_tag_d         = cur_tag_q;
          out_err_d         = 1'b1;
          state_d           = DISP_STATE_IDLE;
        end else begin
          wd_d = wd_q + WD_W'(1);
        end
      end
      default: state_d = DISP_STATE_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q           <= DISP_STATE_IDLE;
      cur_op_q          <= ALU_OP_NOP;
      cur_tag_q         <= '0;
      opnd_q            <= '0;
      wd_q              <= '0;
      out_valid_q       <= 1'b0;
      out_result_q      <= '0;
      out_result_wide_q <= '0;
      out_is_wide_q     <= 1'b0;
      out_tag_q         <= '0;
      out_err_q         <= 1'b0;
    end else begin
      state_q           <= state_d;
      cur_op_q          <= cur_op_d;
      cur_tag_q         <= cur_tag_d;
      opnd_q            <= opnd_d;
      wd_q              <= wd_d;
      out_valid_q       <= out_valid_d;
      out_result_q      <= out_result_d;
      out_result_wide_q <= out_result_wide_d;
      out_is_wide_q     <= out_is_wide_d;
      out_tag_q         <= out_tag_d;
      out_err_q         <= out_err_d;
    end
  end

  assign out_valid       = out_valid_q;
  assign out_result      = out_result_q;
  assign out_result_wide = out_result_wide_q;
  assign out_is_wide     = out_is_wide_q;
  assign out_tag         = out_tag_q;
  assign out_err         = out_err_q;

endmodule
`default_nettype wire

// File: tb/tb_dsp_alu_dispatch.sv
`default_nettype none
// ============================================================================
// Module      : tb_dsp_alu_dispatch
// Description : Directed self-checking bench with a small behavioural ALU.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dsp_alu_dispatch;
  import dsp_alu_dispatch_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_op;
  logic [15:0] in_a, in_b, in_c;
  logic [31:0] in_a_wide, in_b_wide;
  logic [3:0]  in_shift;
  logic        in_no_shift, in_saturate;
  logic [3:0]  in_tag;
  logic        alu_trigger;
  logic [7:0]  alu_op;
  logic [15:0] alu_a, alu_b, alu_c;
  logic [31:0] alu_a_wide, alu_b_wide;
  logic [3:0]  alu_shift;
  logic        alu_no_shift, alu_saturate;
  logic [15:0] alu_result = '0;
  logic [31:0] alu_result_wide = '0;
  logic        alu_result_valid;
  logic        alu_ready = 1'b1;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_result;
  logic [31:0] out_result_wide;
  logic        out_is_wide;
  logic [3:0]  out_tag;
  logic        out_err;

  int total = 0;
  int bad   = 0;

  logic        mute = 1'b0;
  logic        inj_rv = 1'b0;
  logic        model_rv = 1'b0;
  int          pcnt = 0;
  logic [7:0]  p_op = '0;
  logic [15:0] p_a = '0, p_b = '0;
  logic [31:0] p_bw = '0;
  logic [3:0]  p_sh = '0;
  logic        p_ns = 1'b0;

  assign alu_result_valid = model_rv | inj_rv;

  dsp_alu_dispatch #(
    .data_width (16),
    .depth      (4),
    .tag_width  (4),
    .timeout    (8)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .in_op            (in_op),
    .in_a             (in_a),
    .in_b             (in_b),
    .in_c             (in_c),
    .in_a_wide        (in_a_wide),
    .in_b_wide        (in_b_wide),
    .in_shift         (in_shift),
    .in_no_shift      (in_no_shift),
    .in_saturate      (in_saturate),
    .in_tag           (in_tag),
    .alu_trigger      (alu_trigger),
    .alu_op           (alu_op),
    .alu_a            (alu_a),
    .alu_b            (alu_b),
    .alu_c            (alu_c),
    .alu_a_wide       (alu_a_wide),
    .alu_b_wide       (alu_b_wide),
    .alu_shift        (alu_shift),
    .alu_no_shift     (alu_no_shift),
    .alu_saturate     (alu_saturate),
    .alu_result       (alu_result),
    .alu_result_wide  (alu_result_wide),
    .alu_result_valid (alu_result_valid),
    .alu_ready        (alu_ready),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .out_result       (out_result),
    .out_result_wide  (out_result_wide),
    .out_is_wide      (out_is_wide),
    .out_tag          (out_tag),
    .out_err          (out_err)
  );

  always #5 clk = ~clk;

  // Behavioural ALU: {wide, narrow} result of a triggered op.
  function automatic logic [47:0] alu_slow(input logic [7:0] op, input logic [15:0] a,
                                           input logic [15:0] b, input logic [31:0] bw,
                                           input logic [3:0] sh, input logic ns);
    logic [31:0] prod;
    logic [31:0] acc;
    prod = 32'(a) * 32'(b);
    acc  = prod + bw;
    case (op)
      ALU_OP_MUL: alu_slow = {prod, ns ? prod[15:0] : 16'(prod >> sh)};
      ALU_OP_MAC: alu_slow = {acc, acc[15:0]};
      default:    alu_slow = {32'h0, 16'(a << sh)};
    endcase
  endfunction

  function automatic logic [15:0] clamp(input logic [15:0] a, input logic [15:0] lo,
                                        input logic [15:0] hi);
    clamp = (a > hi) ? hi : ((a < lo) ? lo : a);
  endfunction

  always @(posedge clk) begin
    model_rv <= 1'b0;
    if (alu_trigger && !mute) begin
      pcnt <= 2;
      p_op <= alu_op; p_a <= alu_a; p_b <= alu_b;
      p_bw <= alu_b_wide; p_sh <= alu_shift; p_ns <= alu_no_shift;
    end else if (pcnt == 1) begin
      pcnt <= 0;
      model_rv <= 1'b1;
      {alu_result_wide, alu_result} <= alu_slow(p_op, p_a, p_b, p_bw, p_sh, p_ns);
    end else if (pcnt > 1) begin
      pcnt <= pcnt - 1;
    end
    if (!alu_trigger) begin
      case (alu_op)
        ALU_OP_ADD: alu_result <= alu_a + alu_b;
        ALU_OP_SUB: alu_result <= alu_a - alu_b;
        ALU_OP_CLAMP: begin
          alu_result      <= 16'hBAD0;
          alu_result_wide <= {16'h0, clamp(alu_a, alu_b, alu_c)};
        end
        default: ;
      endcase
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_cmd(input logic [7:0] op, input logic [15:0] a, input logic [15:0] b,
                          input logic [15:0] c, input logic [31:0] bw, input logic [3:0] sh,
                          input logic ns, input logic [3:0] tag);
    in_valid = 1'b1; in_op = op; in_a = a; in_b = b; in_c = c;
    in_a_wide = '0; in_b_wide = bw; in_shift = sh; in_no_shift = ns;
    in_saturate = 1'b0; in_tag = tag;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic consume();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic wait_rv(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      tick();
      if (alu_result_valid === 1'b1) ok = 1'b1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: observed=running expected=finished");
    $fatal(1, "bench time limit");
  end

  initial begin
    bit ok;
    int got;
    reset = 1'b0; in_valid = 1'b0; in_op = '0; in_a = '0; in_b = '0; in_c = '0;
    in_a_wide = '0; in_b_wide = '0; in_shift = '0; in_no_shift = 1'b0;
    in_saturate = 1'b0; in_tag = '0; out_ready = 1'b0;

    repeat (3) tick();
    chk("rst_in_ready", in_ready, 1);
    chk("rst_trigger", alu_trigger, 0);
    chk("rst_alu_op", alu_op, ALU_OP_NOP);
    chk("rst_alu_a", alu_a, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_err", out_err, 0);
    chk("rst_out_result", out_result, 0);
    reset = 1'b1;
    tick();

    // ADD: out_valid two cycles after the pop cycle
    push_cmd(ALU_OP_ADD, 16'd100, 16'd23, 16'd0, 32'd0, 4'd0, 1'b0, 4'd3);
    chk("add_issue_op", alu_op, ALU_OP_ADD);
    chk("add_issue_trig", alu_trigger, 0);
    tick();
    chk("add_lat1", out_valid, 0);
    tick();
    chk("add_valid", out_valid, 1);
    chk("add_result", out_result, 123);
    chk("add_tag", out_tag, 3);
    chk("add_is_wide", out_is_wide, 0);
    chk("add_err", out_err, 0);
    consume();
    chk("add_consumed", out_valid, 0);
    chk("idle_nop", alu_op, ALU_OP_NOP);
    chk("idle_hold_a", alu_a, 100);

    // MUL with post-shift
    push_cmd(ALU_OP_MUL, 16'h4000, 16'h4000, 16'd0, 32'd0, 4'd15, 1'b0, 4'd1);
    chk("mul_trig", alu_trigger, 1);
    chk("mul_op", alu_op, ALU_OP_MUL);
    tick();
    chk("mul_trig_pulse", alu_trigger, 0);
    wait_rv(ok);
    chk("mul_rv_seen", ok, 1);
    chk("mul_not_yet", out_valid, 0);
    tick();
    chk("mul_valid", out_valid, 1);
    chk("mul_result", out_result, 16'h2000);
    chk("mul_is_wide", out_is_wide, 0);
    chk("mul_tag", out_tag, 1);
    consume();

    // MAC: wide result
    push_cmd(ALU_OP_MAC, 16'd2, 16'd3, 16'd0, 32'd10, 4'd0, 1'b1, 4'd2);
    chk("mac_trig", alu_trigger, 1);
    wait_rv(ok);
    chk("mac_rv_seen", ok, 1);
    tick();
    chk("mac_valid", out_valid, 1);
    chk("mac_is_wide", out_is_wide, 1);
    chk("mac_wide", out_result_wide, 16);
    chk("mac_tag", out_tag, 2);
    consume();

    // CLAMP takes the low half of the wide result
    push_cmd(ALU_OP_CLAMP, 16'd500, 16'd0, 16'd300, 32'd0, 4'd0, 1'b0, 4'd4);
    tick();
    tick();
    chk("clamp_valid", out_valid, 1);
    chk("clamp_result", out_result, 300);
    consume();

    // Unknown opcode is dropped silently
    push_cmd(8'h55, 16'd1, 16'd1, 16'd0, 32'd0, 4'd0, 1'b0, 4'd7);
    chk("drop_nop", alu_op, ALU_OP_NOP);
    chk("drop_trig", alu_trigger, 0);
    repeat (4) tick();
    chk("drop_no_out", out_valid, 0);
    chk("drop_in_ready", in_ready, 1);

    // Watchdog abort after 8 WAIT cycles
    mute = 1'b1;
    push_cmd(ALU_OP_LSH, 16'd1, 16'd0, 16'd0, 32'd0, 4'd2, 1'b0, 4'd9);
    chk("wd_trig", alu_trigger, 1);
    repeat (8) tick();
    chk("wd_not_yet", out_valid, 0);
    tick();
    chk("wd_valid", out_valid, 1);
    chk("wd_err", out_err, 1);
    chk("wd_result", out_result, 0);
    consume();
    mute = 1'b0;
    push_cmd(ALU_OP_ADD, 16'd1, 16'd2, 16'd0, 32'd0, 4'd0, 1'b0, 4'd5);
    tick();
    tick();
    chk("post_wd_valid", out_valid, 1);
    chk("post_wd_result", out_result, 3);
    chk("post_wd_err", out_err, 0);
    consume();

    // Back-pressure: five ADDs with out_ready low
    for (int i = 0; i < 5; i++) begin
      chk("bp_in_ready_push", in_ready, 1);
      in_valid = 1'b1; in_op = ALU_OP_ADD; in_a = 16'(10 * (i + 1));
      in_b = 16'(i + 1); in_tag = 4'(i + 1);
      tick();
    end
    in_valid = 1'b0;
    chk("bp_full", in_ready, 0);
    chk("bp_first_valid", out_valid, 1);
    chk("bp_first_result", out_result, 11);
    out_ready = 1'b1;
    got = 0;
    for (int i = 0; i < 40 && got < 5; i++) begin
      if (out_valid) begin
        chk("bp_result", out_result, 16'(11 * (got + 1)));
        chk("bp_tag", out_tag, 4'(got + 1));
        got++;
      end
      tick();
    end
    out_ready = 1'b0;
    chk("bp_count", got, 5);
    chk("bp_in_ready_back", in_ready, 1);

    // Reset during WAIT
    mute = 1'b1;
    push_cmd(ALU_OP_MUL, 16'd3, 16'd4, 16'd0, 32'd0, 4'd0, 1'b1, 4'd6);
    chk("rw_trig", alu_trigger, 1);
    tick();
    tick();
    reset = 1'b0;
    #1;
    chk("rw_out_valid", out_valid, 0);
    chk("rw_alu_op", alu_op, ALU_OP_NOP);
    chk("rw_trig_low", alu_trigger, 0);
    chk("rw_alu_a", alu_a, 0);
    chk("rw_in_ready", in_ready, 1);
    chk("rw_out_tag", out_tag, 0);
    chk("rw_out_result", out_result, 0);
    @(negedge clk);
    reset = 1'b1;
    mute = 1'b0;
    tick();
    inj_rv = 1'b1;
    tick();
    inj_rv = 1'b0;
    repeat (3) tick();
    chk("rw_late_rv_ignored", out_valid, 0);
    push_cmd(ALU_OP_ADD, 16'd7, 16'd8, 16'd0, 32'd0, 4'd0, 1'b0, 4'd2);
    tick();
    tick();
    chk("rw_add_valid", out_valid, 1);
    chk("rw_add_result", out_result, 15);
    consume();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
